// File: rtl/rvv_alu_pkg.sv
// Shared definitions for the RVV integer ALU engine: funct6 codes, operand-type
// codes, FSM state encoding and the SEW decode helper.
package rvv_alu_pkg;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000010;
   localparam logic [5:0] OP_RSUB = 6'b000011;
   localparam logic [5:0] OP_MINU = 6'b000100;
   localparam logic [5:0] OP_MIN  = 6'b000101;
   localparam logic [5:0] OP_MAXU = 6'b000110;
   localparam logic [5:0] OP_MAX  = 6'b000111;
   localparam logic [5:0] OP_AND  = 6'b001001;
   localparam logic [5:0] OP_OR   = 6'b001010;
   localparam logic [5:0] OP_XOR  = 6'b001011;

   localparam logic [2:0] OPT_VV = 3'b001;
   localparam logic [2:0] OPT_VX = 3'b010;
   localparam logic [2:0] OPT_VI = 3'b100;

   // Logic-op selector equals the low two bits of the matching funct6.
   localparam logic [1:0] LOP_AND = 2'b01;
   localparam logic [1:0] LOP_OR  = 2'b10;
   localparam logic [1:0] LOP_XOR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [6:0] sew_bits(input logic [2:0] vsew);
      return 7'd8 << vsew;
   endfunction

endpackage

// File: rtl/rvv_alu_lane.sv
// One LANE_W slice of the beat datapath: byte-segmented ripple adder whose
// carry restarts at every element boundary, plus bitwise logic ops.
module rvv_alu_lane
   import rvv_alu_pkg::*;
#(
   parameter int LANE_W = 32
) (
   input  logic [LANE_W-1:0]   x,
   input  logic [LANE_W-1:0]   y,
   input  logic                cin,
   input  logic                sub_mode,
   input  logic                logic_en,
   input  logic [1:0]          logic_op,
   input  logic [LANE_W/8-1:0] byte_start,
   output logic [LANE_W-1:0]   res,
   output logic [LANE_W/8-1:0] byte_cout,
   output logic                cout
);

   localparam int NB = LANE_W / 8;

   logic [LANE_W-1:0] sum;
   logic [LANE_W-1:0] lres;
   logic [8:0]        bsum;
   logic              c;
   logic              cb;

   always_comb begin
      sum       = '0;
      byte_cout = '0;
      bsum      = '0;
      c         = cin;
      cb        = 1'b0;
      for (int b = 0; b < NB; b++) begin
         // An element's first byte takes the +1 of a subtract, never a neighbour's carry.
         cb           = byte_start[b] ? sub_mode : c;
         bsum         = {1'b0, x[b*8 +: 8]} + {1'b0, y[b*8 +: 8]} + {8'd0, cb};
         sum[b*8 +: 8] = bsum[7:0];
         byte_cout[b] = bsum[8];
         c            = bsum[8];
      end
      cout = c;
   end

   always_comb begin
      unique case (logic_op)
         LOP_AND: lres = x & y;
         LOP_OR:  lres = x | y;
         default: lres = x ^ y;
      endcase
   end

   assign res = logic_en ? lres : sum;

endmodule

// File: rtl/rvv_alu_engine.sv
// Multi-beat vector integer ALU: one whole-register op streamed NUM_LANES*LANE_W
// bits per cycle, tail-undisturbed merge. Masking enabled by RVV_ALU_MASK_EN.
module rvv_alu_engine
   import rvv_alu_pkg::*;
#(
   parameter int VLEN      = 128,
   parameter int LANE_W    = 32,
   parameter int NUM_LANES = 2
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [5:0]               opcode,
   input  logic [2:0]               op_type,
   input  logic [2:0]               vsew,
   input  logic [$clog2(VLEN):0]    vl,
   input  logic [VLEN-1:0]          vs1,
   input  logic [VLEN-1:0]          vs2,
   input  logic [63:0]              rs1,
   input  logic [4:0]               imm,
   input  logic [VLEN-1:0]          vd_old,
`ifdef RVV_ALU_MASK_EN
   input  logic                     vm,
   input  logic [VLEN-1:0]          v0,
`endif
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [VLEN-1:0]          vd,
   output logic                     err
);

   localparam int BEAT_W = NUM_LANES * LANE_W;
   localparam int BEATS  = VLEN / BEAT_W;
   localparam int BEAT_B = BEAT_W / 8;
   localparam int LANE_B = LANE_W / 8;
   localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int VLW    = $clog2(VLEN) + 1;

   function automatic logic illegal_req(input logic [5:0] opc, input logic [2:0] typ,
                                        input logic [2:0] sew);
      logic op_ok;
      logic typ_ok;
      op_ok  = opc inside {OP_ADD, OP_SUB, OP_RSUB, OP_MINU, OP_MIN, OP_MAXU, OP_MAX,
                           OP_AND, OP_OR, OP_XOR};
      typ_ok = typ inside {OPT_VV, OPT_VX, OPT_VI};
      return !op_ok || !typ_ok || sew[2];
   endfunction

   function automatic logic [VLEN-1:0] replicate(input logic [63:0] s, input logic [1:0] vs);
      unique case (sew_bits({1'b0, vs}))
         7'd8:    return {(VLEN/8){s[7:0]}};
         7'd16:   return {(VLEN/16){s[15:0]}};
         7'd32:   return {(VLEN/32){s[31:0]}};
         default: return {(VLEN/64){s}};
      endcase
   endfunction

   state_t                         state_q, state_d;
   logic [BW-1:0]                  beat_q;
   logic                           err_q;
   logic [BEATS-1:0][BEAT_W-1:0]   vd_q, vs2_q, op1_q;
   logic [5:0]                     op_q;
   logic [1:0]                     vsew_q;
   logic [VLW-1:0]                 vl_q;
   logic [VLEN-1:0]                op1_in;
   logic                           accept, last_beat;
`ifdef RVV_ALU_MASK_EN
   logic                           vm_q;
   logic [VLEN-1:0]                v0_q;
`endif

   always_comb begin
      unique case (op_type)
         OPT_VX:  op1_in = replicate(rs1, vsew[1:0]);
         OPT_VI:  op1_in = replicate({{59{imm[4]}}, imm}, vsew[1:0]);
         default: op1_in = vs1;
      endcase
   end

   assign accept    = in_valid && (state_q == ST_IDLE);
   assign last_beat = (beat_q == BW'(BEATS - 1));

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = ST_RUN;
         end
         ST_RUN:  if (last_beat) state_d = ST_DONE;
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---- beat datapath: operand slice -> lane chain -> select/merge ----
   logic                is_add, is_rsub, is_logic, is_minmax, sub_mode;
   logic [BEAT_W-1:0]   vs2_s, op1_s, old_s, x_b, y_b, res_b, beat_res;
   logic [BEAT_B-1:0]   byte_start, bc;
   logic [NUM_LANES-1:0] lane_cin, lane_cout;
   logic [3:0]          bs_v, ltu_v, lts_v;
   logic                xs, ys, ss, lt, pick_vs2, active, mask_ok;
   logic [7:0]          val;
   logic [VLW-1:0]      gbyte, elem;
   logic                unused_cout;

   assign is_add    = (op_q == OP_ADD);
   assign is_rsub   = (op_q == OP_RSUB);
   assign is_logic  = op_q inside {OP_AND, OP_OR, OP_XOR};
   assign is_minmax = (op_q[5:2] == 4'b0001);
   assign sub_mode  = !is_add && !is_logic;

   assign vs2_s = vs2_q[beat_q];
   assign op1_s = op1_q[beat_q];
   assign old_s = vd_q[beat_q];
   assign x_b   = is_rsub ? op1_s : vs2_s;
   assign y_b   = (is_add || is_logic) ? op1_s : (is_rsub ? ~vs2_s : ~op1_s);

   always_comb begin
      byte_start = '0;
      bs_v       = '0;
      for (int j = 0; j < BEAT_B; j++) begin
         bs_v          = {(j % 8) == 0, (j % 4) == 0, (j % 2) == 0, 1'b1};
         byte_start[j] = bs_v[vsew_q];
      end
   end

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      if (k == 0) begin : g_first
         assign lane_cin[k] = sub_mode;
      end else begin : g_chain
         assign lane_cin[k] = lane_cout[k-1];
      end
      rvv_alu_lane #(.LANE_W(LANE_W)) u_lane (
         .x          (x_b[k*LANE_W +: LANE_W]),
         .y          (y_b[k*LANE_W +: LANE_W]),
         .cin        (lane_cin[k]),
         .sub_mode   (sub_mode),
         .logic_en   (is_logic),
         .logic_op   (op_q[1:0]),
         .byte_start (byte_start[k*LANE_B +: LANE_B]),
         .res        (res_b[k*LANE_W +: LANE_W]),
         .byte_cout  (bc[k*LANE_B +: LANE_B]),
         .cout       (lane_cout[k])
      );
   end

   assign unused_cout = lane_cout[NUM_LANES-1];

   always_comb begin
      beat_res = old_s;
      ltu_v    = '0;
      lts_v    = '0;
      xs       = 1'b0;
      ys       = 1'b0;
      ss       = 1'b0;
      lt       = 1'b0;
      pick_vs2 = 1'b0;
      val      = '0;
      gbyte    = '0;
      elem     = '0;
      mask_ok  = 1'b1;
      active   = 1'b0;
      for (int j = 0; j < BEAT_B; j++) begin
         // Compare result comes from the top byte of the element holding byte j.
         for (int s = 0; s < 4; s++) begin
            ltu_v[s] = !bc[j | ((1 << s) - 1)];
            xs       = x_b[(j | ((1 << s) - 1)) * 8 + 7];
            ys       = y_b[(j | ((1 << s) - 1)) * 8 + 7];
            ss       = res_b[(j | ((1 << s) - 1)) * 8 + 7];
            lts_v[s] = ss ^ ((xs == ys) && (ss != xs));
         end
         lt       = op_q[0] ? lts_v[vsew_q] : ltu_v[vsew_q];
         pick_vs2 = op_q[1] ? !lt : lt;
         val      = is_minmax ? (pick_vs2 ? vs2_s[j*8 +: 8] : op1_s[j*8 +: 8])
                              : res_b[j*8 +: 8];
         gbyte    = VLW'(beat_q) * VLW'(BEAT_B) + VLW'(j);
         elem     = gbyte >> vsew_q;
`ifdef RVV_ALU_MASK_EN
         mask_ok  = vm_q || v0_q[elem[VLW-2:0]];
`else
         mask_ok  = 1'b1;
`endif
         active   = !err_q && (elem < vl_q) && mask_ok;
         if (active) beat_res[j*8 +: 8] = val;
      end
   end

   // ---- state / result registers ----
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         err_q   <= 1'b0;
         vd_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            beat_q <= '0;
            err_q  <= illegal_req(opcode, op_type, vsew);
            vd_q   <= vd_old;
         end else if (state_q == ST_RUN) begin
            beat_q         <= beat_q + 1'b1;
            vd_q[beat_q]   <= beat_res;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         op_q   <= opcode;
         vsew_q <= vsew[1:0];
         vl_q   <= vl;
         vs2_q  <= vs2;
         op1_q  <= op1_in;
`ifdef RVV_ALU_MASK_EN
         vm_q   <= vm;
         v0_q   <= v0;
`endif
      end
   end

   assign vd  = vd_q;
   assign err = err_q;

endmodule

// File: tb/tb_rvv_alu_engine.sv
// Bench for rvv_alu_engine: directed vector table, randomized ops against an
// element-level reference model, and handshake/reset sequences.
module tb_rvv_alu_engine;
   import rvv_alu_pkg::*;

   localparam int VLEN      = 128;
   localparam int LANE_W    = 32;
   localparam int NUM_LANES = 2;
   localparam int BEATS     = VLEN / (LANE_W * NUM_LANES);
   localparam int VLW       = $clog2(VLEN) + 1;

   logic            clk, resetn, in_valid, in_ready, out_valid, out_ready, err;
   logic [5:0]      opcode;
   logic [2:0]      op_type, vsew;
   logic [VLW-1:0]  vl;
   logic [VLEN-1:0] vs1, vs2, vd_old, vd;
   logic [63:0]     rs1;
   logic [4:0]      imm;
`ifdef RVV_ALU_MASK_EN
   logic            vm;
   logic [VLEN-1:0] v0;
`endif

   int errors = 0;
   int checks = 0;

   typedef struct {
      string           name;
      logic [5:0]      opc;
      logic [2:0]      typ;
      logic [2:0]      vsew;
      logic [VLW-1:0]  vl;
      logic [VLEN-1:0] vs1;
      logic [VLEN-1:0] vs2;
      logic [63:0]     rs1;
      logic [4:0]      imm;
      logic [VLEN-1:0] vd_old;
      logic [VLEN-1:0] exp_vd;
      logic            exp_err;
   } vec_t;

   vec_t tbl [11];
   logic [5:0] ops [10] = '{OP_ADD, OP_SUB, OP_RSUB, OP_MINU, OP_MIN, OP_MAXU, OP_MAX,
                            OP_AND, OP_OR, OP_XOR};

   rvv_alu_engine #(.VLEN(VLEN), .LANE_W(LANE_W), .NUM_LANES(NUM_LANES)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .op_type   (op_type),
      .vsew      (vsew),
      .vl        (vl),
      .vs1       (vs1),
      .vs2       (vs2),
      .rs1       (rs1),
      .imm       (imm),
      .vd_old    (vd_old),
`ifdef RVV_ALU_MASK_EN
      .vm        (vm),
      .v0        (v0),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .vd        (vd),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input string n, input logic [5:0] opc, input logic [2:0] typ,
                               input logic [2:0] sw, input logic [VLW-1:0] l,
                               input logic [VLEN-1:0] a1, input logic [VLEN-1:0] a2,
                               input logic [63:0] r, input logic [4:0] im,
                               input logic [VLEN-1:0] old, input logic [VLEN-1:0] ev,
                               input logic ee);
      vec_t v;
      v.name = n; v.opc = opc; v.typ = typ; v.vsew = sw; v.vl = l;
      v.vs1 = a1; v.vs2 = a2; v.rs1 = r; v.imm = im; v.vd_old = old;
      v.exp_vd = ev; v.exp_err = ee;
      return v;
   endfunction

   // Element-by-element reference: plain integer arithmetic on each SEW-wide element.
   function automatic logic [VLEN-1:0] model(input vec_t v, input logic vm_i,
                                             input logic [VLEN-1:0] v0_i, output logic err_o);
      logic [VLEN-1:0]  r;
      longint unsigned  a, b, res, msk;
      longint           sa, sb;
      int               sew, nel;
      r     = v.vd_old;
      err_o = !(v.opc inside {OP_ADD, OP_SUB, OP_RSUB, OP_MINU, OP_MIN, OP_MAXU, OP_MAX,
                              OP_AND, OP_OR, OP_XOR})
              || !(v.typ inside {OPT_VV, OPT_VX, OPT_VI}) || (v.vsew > 3'd3);
      if (err_o) return r;
      sew = 8 << v.vsew;
      nel = VLEN / sew;
      msk = (sew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << sew) - 64'd1);
      for (int i = 0; i < nel; i++) begin
         if (i < int'(v.vl) && (vm_i || v0_i[i])) begin
            a = 64'(v.vs2 >> (i * sew)) & msk;
            case (v.typ)
               OPT_VX:  b = v.rs1 & msk;
               OPT_VI:  b = 64'(longint'($signed(v.imm))) & msk;
               default: b = 64'(v.vs1 >> (i * sew)) & msk;
            endcase
            sa = a[sew-1] ? (a | ~msk) : a;
            sb = b[sew-1] ? (b | ~msk) : b;
            case (v.opc)
               OP_ADD:  res = a + b;
               OP_SUB:  res = a - b;
               OP_RSUB: res = b - a;
               OP_MINU: res = (a < b) ? a : b;
               OP_MIN:  res = (sa < sb) ? a : b;
               OP_MAXU: res = (a > b) ? a : b;
               OP_MAX:  res = (sa > sb) ? a : b;
               OP_AND:  res = a & b;
               OP_OR:   res = a | b;
               default: res = a ^ b;
            endcase
            res = res & msk;
            r = (r & ~(VLEN'(msk) << (i * sew))) | (VLEN'(res) << (i * sew));
         end
      end
      return r;
   endfunction

   function automatic logic [VLEN-1:0] r128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      opcode = v.opc; op_type = v.typ; vsew = v.vsew; vl = v.vl;
      vs1 = v.vs1; vs2 = v.vs2; rs1 = v.rs1; imm = v.imm; vd_old = v.vd_old;
      in_valid = 1'b1;
   endtask

   // Accept one op, wait (bounded) for out_valid, optionally consume it.
   task automatic do_op(input vec_t v, input logic release_out,
                        output logic [VLEN-1:0] r, output logic e, output int lat);
      drive(v);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      r = vd;
      e = err;
      if (release_out) begin
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
   endtask

   initial begin
      logic [VLEN-1:0] r, ev, hold_vd, v0_i;
      logic            e, ee, vm_i;
      int              lat;
      vec_t            v;

      resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      opcode = '0; op_type = OPT_VV; vsew = '0; vl = '0;
      vs1 = '0; vs2 = '0; rs1 = '0; imm = '0; vd_old = '0;
`ifdef RVV_ALU_MASK_EN
      vm = 1'b1; v0 = '0;
`endif
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      check("reset in_ready", VLEN'(in_ready), VLEN'(1));
      check("reset out_valid", VLEN'(out_valid), '0);
      check("reset vd", vd, '0);
      check("reset err", VLEN'(err), '0);
      @(posedge clk); #1;

      tbl[0]  = mk("vadd_vv_sew32", OP_ADD, OPT_VV, 3'd2, 8'd4, {4{32'h1}}, '1, 64'd0, 5'd0,
                   {8{16'h5555}}, '0, 1'b0);
      tbl[1]  = mk("vsub_vx_sew64", OP_SUB, OPT_VX, 3'd3, 8'd2, '0, {64'd5, 64'd0}, 64'd1, 5'd0,
                   '0, {64'd4, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0);
      tbl[2]  = mk("vmin_vv_sew8", OP_MIN, OPT_VV, 3'd0, 8'd16, {16{8'h01}}, {16{8'h80}}, 64'd0,
                   5'd0, '0, {16{8'h80}}, 1'b0);
      tbl[3]  = mk("vminu_vv_sew8", OP_MINU, OPT_VV, 3'd0, 8'd16, {16{8'h01}}, {16{8'h80}}, 64'd0,
                   5'd0, '0, {16{8'h01}}, 1'b0);
      tbl[4]  = mk("vand_vi_sew16_tail", OP_AND, OPT_VI, 3'd1, 8'd3, '0,
                   128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 64'd0, 5'b11111, {8{16'hAAAA}},
                   128'hAAAA_AAAA_AAAA_AAAA_AAAA_BA98_7654_3210, 1'b0);
      tbl[5]  = mk("illegal_opcode", 6'b111111, OPT_VV, 3'd2, 8'd4, '1, '1, 64'd0, 5'd0,
                   {4{32'hDEAD_BEEF}}, {4{32'hDEAD_BEEF}}, 1'b1);
      tbl[6]  = mk("vl_zero", OP_ADD, OPT_VV, 3'd0, 8'd0, '1, '1, 64'd0, 5'd0,
                   {4{32'h1234_5678}}, {4{32'h1234_5678}}, 1'b0);
      tbl[7]  = mk("vrsub_vi_vl_clamp", OP_RSUB, OPT_VI, 3'd3, 8'd100, '0, {64'd3, 64'd10}, 64'd0,
                   5'd1, '0, {64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF7}, 1'b0);
      tbl[8]  = mk("vmax_vv_sew16", OP_MAX, OPT_VV, 3'd1, 8'd8, {8{16'h0001}}, {8{16'hFFFF}},
                   64'd0, 5'd0, '0, {8{16'h0001}}, 1'b0);
      tbl[9]  = mk("illegal_vsew", OP_ADD, OPT_VV, 3'd4, 8'd4, '1, '1, 64'd0, 5'd0,
                   {8{16'h7777}}, {8{16'h7777}}, 1'b1);
      tbl[10] = mk("illegal_optype", OP_ADD, 3'b011, 3'd2, 8'd4, '1, '1, 64'd0, 5'd0,
                   {8{16'h3C3C}}, {8{16'h3C3C}}, 1'b1);

      for (int i = 0; i < 11; i++) begin
         do_op(tbl[i], 1'b1, r, e, lat);
         check({tbl[i].name, " vd"}, r, tbl[i].exp_vd);
         check({tbl[i].name, " err"}, VLEN'(e), VLEN'(tbl[i].exp_err));
         check({tbl[i].name, " latency"}, VLEN'(lat), VLEN'(BEATS + 1));
      end

`ifdef RVV_ALU_MASK_EN
      vm = 1'b0;
      v0 = VLEN'(4'b0101);
      v = mk("masked_vadd", OP_ADD, OPT_VV, 3'd2, 8'd4, {4{32'h2}}, {4{32'h1}}, 64'd0, 5'd0,
             128'h4444_4444_3333_3333_2222_2222_1111_1111,
             128'h4444_4444_0000_0003_2222_2222_0000_0003, 1'b0);
      do_op(v, 1'b1, r, e, lat);
      check("masked_vadd vd", r, v.exp_vd);
      v.opc = 6'b111111;
      do_op(v, 1'b1, r, e, lat);
      check("masked_illegal vd", r, v.vd_old);
      check("masked_illegal err", VLEN'(e), VLEN'(1));
      vm = 1'b1;
`endif

      for (int n = 0; n < 120; n++) begin
         v.name = "random";
         v.opc  = ($urandom_range(0, 15) == 0) ? 6'(($urandom & 6'h30) | 6'h0C) : ops[$urandom_range(0, 9)];
         case ($urandom_range(0, 15))
            0:       v.typ = 3'b011;
            1, 2, 3, 4, 5: v.typ = OPT_VX;
            6, 7, 8, 9, 10: v.typ = OPT_VI;
            default: v.typ = OPT_VV;
         endcase
         v.vsew   = ($urandom_range(0, 15) == 0) ? 3'd5 : 3'($urandom_range(0, 3));
         v.vl     = ($urandom_range(0, 7) == 0) ? VLW'(VLEN) : VLW'($urandom_range(0, 18));
         v.vs1    = ($urandom_range(0, 5) == 0) ? '1 : r128();
         v.vs2    = ($urandom_range(0, 5) == 0) ? '1 : r128();
         v.rs1    = {$urandom, $urandom};
         v.imm    = 5'($urandom);
         v.vd_old = r128();
         vm_i = 1'b1;
         v0_i = '0;
`ifdef RVV_ALU_MASK_EN
         vm_i = 1'($urandom);
         v0_i = r128();
         vm = vm_i;
         v0 = v0_i;
`endif
         ev = model(v, vm_i, v0_i, ee);
         do_op(v, 1'b1, r, e, lat);
         check($sformatf("random%0d op=%0h sew=%0d vl=%0d vd", n, v.opc, v.vsew, v.vl), r, ev);
         check($sformatf("random%0d err", n), VLEN'(e), VLEN'(ee));
      end
`ifdef RVV_ALU_MASK_EN
      vm = 1'b1;
`endif

      // Result held under back-pressure.
      do_op(tbl[4], 1'b0, hold_vd, e, lat);
      check("hold initial vd", hold_vd, tbl[4].exp_vd);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("hold%0d out_valid", c), VLEN'(out_valid), VLEN'(1));
         check($sformatf("hold%0d in_ready", c), VLEN'(in_ready), '0);
         check($sformatf("hold%0d vd", c), vd, hold_vd);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("release out_valid", VLEN'(out_valid), '0);
      check("release in_ready", VLEN'(in_ready), VLEN'(1));

      // Reset asserted while beats are in flight.
      drive(tbl[4]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("midrun in_ready", VLEN'(in_ready), '0);
      resetn = 1'b0;
      @(posedge clk); #1;
      check("midrun reset in_ready", VLEN'(in_ready), VLEN'(1));
      check("midrun reset out_valid", VLEN'(out_valid), '0);
      check("midrun reset vd", vd, '0);
      check("midrun reset err", VLEN'(err), '0);
      resetn = 1'b1;
      @(posedge clk); #1;
      do_op(tbl[1], 1'b1, r, e, lat);
      check("after reset vd", r, tbl[1].exp_vd);
      check("after reset latency", VLEN'(lat), VLEN'(BEATS + 1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
